// File: rtl/noc_router_vc.sv
// noc_router_vc: five-port XY mesh router with VCs, wormhole locks and credits.
// Optional NOC_ROUTER_VC_STATS_EN builds per-output flit counters.
module noc_router_vc #(
   parameter int DATA_WIDTH = 256,
   parameter int COORD_BITS = 4,
   parameter int NUM_VC     = 2,
   parameter int BUF_DEPTH  = 4,
   parameter int ROUTER_X   = 0,
   parameter int ROUTER_Y   = 0,
   localparam int VC_BITS   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int FLIT_W    = DATA_WIDTH + 2*COORD_BITS + 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [5*FLIT_W-1:0]  in_flit,
   input  logic [5*VC_BITS-1:0] in_vc,
   input  logic [4:0]           in_valid,
   output logic [5*NUM_VC-1:0]  credit_out,
   output logic [5*FLIT_W-1:0]  out_flit,
   output logic [5*VC_BITS-1:0] out_vc,
   output logic [4:0]           out_valid,
   input  logic [5*NUM_VC-1:0]  credit_in,
   output logic [4:0]           err_overflow,
   output logic [4:0]           err_protocol,
   input  logic [2:0]           stat_sel,
   output logic [31:0]          stat_count
);
   localparam int NP = 5;
   localparam int NQ = NP * NUM_VC;
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int XL = DATA_WIDTH;
   localparam int YL = DATA_WIDTH + COORD_BITS;
   localparam int HB = FLIT_W - 2;
   localparam int TB = FLIT_W - 1;
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

   typedef enum logic {IDLE, ACTIVE} vc_state_e;

   function automatic logic [2:0] xy_route(
      input logic [COORD_BITS-1:0] x,
      input logic [COORD_BITS-1:0] y
   );
      if (int'(x) < ROUTER_X) return 3'd3;
      if (int'(x) > ROUTER_X) return 3'd2;
      if (int'(y) < ROUTER_Y) return 3'd1;
      if (int'(y) > ROUTER_Y) return 3'd0;
      return 3'd4;
   endfunction

   function automatic int oq(input logic [2:0] o, input int q);
      return int'(o) * NUM_VC + q % NUM_VC;
   endfunction

   logic [FLIT_W-1:0]  mem [NQ][BUF_DEPTH];
   logic [PW-1:0]      wr_ptr [NQ];
   logic [PW-1:0]      rd_ptr [NQ];
   logic [CW-1:0]      cnt [NQ];
   logic [CW-1:0]      cred [NQ];
   logic [2:0]         route [NQ];
   vc_state_e          vst [NQ];
   vc_state_e          vst_nxt [NQ];
   logic [NQ-1:0]      lock;
   logic [VC_BITS-1:0] vc_ptr [NP];
   logic [2:0]         in_ptr [NP];

   logic [FLIT_W-1:0]  hd [NQ];
   logic [2:0]         tgt [NQ];
   logic [NQ-1:0]      elig, drop, pop, wr, send, lk_set, lk_clr;
   logic [NP-1:0]      sel_v, out_g, in_g, ovf, perr;
   logic [VC_BITS-1:0] sel_vc [NP];
   logic [2:0]         sel_o [NP];
   logic [2:0]         win [NP];
   logic [FLIT_W-1:0]  g_flit [NP];
   logic [VC_BITS-1:0] g_vc [NP];
   int                 gq [NP];

   always_comb begin
      for (int q = 0; q < NQ; q++) begin
         hd[q]  = mem[q][rd_ptr[q]];
         tgt[q] = (vst[q] == ACTIVE) ? route[q]
                : xy_route(hd[q][XL +: COORD_BITS], hd[q][YL +: COORD_BITS]);
         drop[q] = (cnt[q] != '0) && (vst[q] == IDLE) && !hd[q][HB];
         elig[q] = (cnt[q] != '0)
                && ((vst[q] == ACTIVE) || hd[q][HB])
                && (cred[oq(tgt[q], q)] != '0)
                && ((vst[q] == ACTIVE) || !lock[oq(tgt[q], q)]);
      end
      // stage 1: one VC per input
      for (int p = 0; p < NP; p++) begin
         sel_v[p]  = 1'b0;
         sel_vc[p] = '0;
         sel_o[p]  = '0;
         for (int k = 0; k < NUM_VC; k++) begin
            if (!sel_v[p] && elig[p*NUM_VC + (int'(vc_ptr[p]) + k) % NUM_VC]) begin
               sel_v[p]  = 1'b1;
               sel_vc[p] = VC_BITS'((int'(vc_ptr[p]) + k) % NUM_VC);
               sel_o[p]  = tgt[p*NUM_VC + (int'(vc_ptr[p]) + k) % NUM_VC];
            end
         end
      end
      // stage 2: one input per output
      in_g   = '0;
      send   = '0;
      lk_set = '0;
      lk_clr = '0;
      for (int o = 0; o < NP; o++) begin
         out_g[o] = 1'b0;
         win[o]   = '0;
         for (int k = 0; k < NP; k++) begin
            if (!out_g[o] && sel_v[(int'(in_ptr[o]) + k) % NP]
                && sel_o[(int'(in_ptr[o]) + k) % NP] == 3'(o)) begin
               out_g[o] = 1'b1;
               win[o]   = 3'((int'(in_ptr[o]) + k) % NP);
            end
         end
         g_vc[o]   = sel_vc[win[o]];
         gq[o]     = int'(win[o]) * NUM_VC + int'(g_vc[o]);
         g_flit[o] = hd[gq[o]];
         if (out_g[o]) begin
            in_g[win[o]] = 1'b1;
            send[o*NUM_VC + int'(g_vc[o])]   = 1'b1;
            lk_set[o*NUM_VC + int'(g_vc[o])] = (vst[gq[o]] == IDLE) && !g_flit[o][TB];
            lk_clr[o*NUM_VC + int'(g_vc[o])] = (vst[gq[o]] == ACTIVE) && g_flit[o][TB];
         end
      end
      for (int p = 0; p < NP; p++) begin
         for (int v = 0; v < NUM_VC; v++) begin
            vst_nxt[p*NUM_VC+v] = vst[p*NUM_VC+v];
            pop[p*NUM_VC+v] = drop[p*NUM_VC+v]
                           || (in_g[p] && sel_vc[p] == VC_BITS'(v));
            if (in_g[p] && sel_vc[p] == VC_BITS'(v)) begin
               if (vst[p*NUM_VC+v] == IDLE && !hd[p*NUM_VC+v][TB])
                  vst_nxt[p*NUM_VC+v] = ACTIVE;
               else if (vst[p*NUM_VC+v] == ACTIVE && hd[p*NUM_VC+v][TB])
                  vst_nxt[p*NUM_VC+v] = IDLE;
            end
         end
      end
      // a pop on a full FIFO frees the slot for this cycle's write
      wr = '0;
      for (int p = 0; p < NP; p++) begin
         ovf[p]  = 1'b0;
         perr[p] = |drop[p*NUM_VC +: NUM_VC];
         if (in_valid[p] && int'(in_vc[p*VC_BITS +: VC_BITS]) < NUM_VC) begin
            if (cnt[p*NUM_VC + int'(in_vc[p*VC_BITS +: VC_BITS])] != FULL
                || pop[p*NUM_VC + int'(in_vc[p*VC_BITS +: VC_BITS])])
               wr[p*NUM_VC + int'(in_vc[p*VC_BITS +: VC_BITS])] = 1'b1;
            else
               ovf[p] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int q = 0; q < NQ; q++) begin
         if (wr[q]) mem[q][wr_ptr[q]] <= in_flit[(q/NUM_VC)*FLIT_W +: FLIT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int q = 0; q < NQ; q++) begin
            wr_ptr[q] <= '0;
            rd_ptr[q] <= '0;
            cnt[q]    <= '0;
            cred[q]   <= FULL;
            route[q]  <= '0;
            vst[q]    <= IDLE;
         end
         for (int p = 0; p < NP; p++) begin
            vc_ptr[p] <= '0;
            in_ptr[p] <= '0;
         end
         lock         <= '0;
         credit_out   <= '0;
         out_flit     <= '0;
         out_vc       <= '0;
         out_valid    <= '0;
         err_overflow <= '0;
         err_protocol <= '0;
      end else begin
         for (int q = 0; q < NQ; q++) begin
            if (wr[q]) wr_ptr[q] <= wr_ptr[q] + 1'b1;
            if (pop[q]) rd_ptr[q] <= rd_ptr[q] + 1'b1;
            if (wr[q] && !pop[q]) cnt[q] <= cnt[q] + 1'b1;
            else if (!wr[q] && pop[q]) cnt[q] <= cnt[q] - 1'b1;
            if (send[q] && !credit_in[q]) cred[q] <= cred[q] - 1'b1;
            else if (!send[q] && credit_in[q] && cred[q] != FULL)
               cred[q] <= cred[q] + 1'b1;
            if (lk_set[q]) lock[q] <= 1'b1;
            else if (lk_clr[q]) lock[q] <= 1'b0;
            if (vst[q] == IDLE && vst_nxt[q] == ACTIVE) route[q] <= tgt[q];
            vst[q] <= vst_nxt[q];
         end
         for (int p = 0; p < NP; p++) begin
            if (in_g[p]) vc_ptr[p] <= VC_BITS'((int'(sel_vc[p]) + 1) % NUM_VC);
            if (out_g[p]) begin
               in_ptr[p] <= 3'((int'(win[p]) + 1) % NP);
               out_flit[p*FLIT_W +: FLIT_W] <= g_flit[p];
               out_vc[p*VC_BITS +: VC_BITS] <= g_vc[p];
            end
         end
         out_valid    <= out_g;
         credit_out   <= pop;
         err_overflow <= err_overflow | ovf;
         err_protocol <= err_protocol | perr;
      end
   end

`ifdef NOC_ROUTER_VC_STATS_EN
   logic [31:0] stat_q [NP];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int o = 0; o < NP; o++) stat_q[o] <= '0;
      end else begin
         for (int o = 0; o < NP; o++)
            if (out_valid[o]) stat_q[o] <= stat_q[o] + 32'd1;
      end
   end

   always_comb begin
      stat_count = '0;
      for (int o = 0; o < NP; o++)
         if (stat_sel == 3'(o)) stat_count = stat_q[o];
   end
`else
   logic unused_stat;
   assign unused_stat = ^stat_sel;
   assign stat_count  = '0;
`endif

endmodule

// File: tb/tb_noc_router_vc.sv
// tb_noc_router_vc: directed checks of routing, wormhole locks, credits,
// arbitration, error flags and statistics on a node at (1,1).
module tb_noc_router_vc;
   localparam int DW = 16;
   localparam int CB = 4;
   localparam int NV = 2;
   localparam int BD = 4;
   localparam int VB = 1;
   localparam int FW = DW + 2*CB + 2;
   localparam int PN = 0;
   localparam int PS = 1;
   localparam int PE = 2;
   localparam int PW = 3;
   localparam int PL = 4;
`ifdef NOC_ROUTER_VC_STATS_EN
   localparam int STAT_N = 7;
`else
   localparam int STAT_N = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [5*FW-1:0] in_flit;
   logic [5*VB-1:0] in_vc;
   logic [4:0]      in_valid;
   logic [5*NV-1:0] credit_out;
   logic [5*FW-1:0] out_flit;
   logic [5*VB-1:0] out_vc;
   logic [4:0]      out_valid;
   logic [5*NV-1:0] credit_in;
   logic [4:0]      err_overflow;
   logic [4:0]      err_protocol;
   logic [2:0]      stat_sel;
   logic [31:0]     stat_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dep [5];
   int crd [10];
   logic [DW-1:0] e_data [$];
   logic          e_vc [$];
   int            e_cyc [$];
   logic [DW-1:0] exp3 [6];
   logic          exv3 [6];

   noc_router_vc #(
      .DATA_WIDTH(DW), .COORD_BITS(CB), .NUM_VC(NV),
      .BUF_DEPTH(BD), .ROUTER_X(1), .ROUTER_Y(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_flit(in_flit), .in_vc(in_vc), .in_valid(in_valid),
      .credit_out(credit_out),
      .out_flit(out_flit), .out_vc(out_vc), .out_valid(out_valid),
      .credit_in(credit_in),
      .err_overflow(err_overflow), .err_protocol(err_protocol),
      .stat_sel(stat_sel), .stat_count(stat_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         for (int p = 0; p < 5; p++) dep[p] = 0;
         for (int b = 0; b < 10; b++) crd[b] = 0;
         e_data.delete();
         e_vc.delete();
         e_cyc.delete();
      end else begin
         for (int p = 0; p < 5; p++) if (out_valid[p]) dep[p]++;
         for (int b = 0; b < 10; b++) if (credit_out[b]) crd[b]++;
         if (out_valid[PE]) begin
            e_data.push_back(out_flit[PE*FW +: DW]);
            e_vc.push_back(out_vc[PE]);
            e_cyc.push_back(cyc);
         end
      end
   end

   task automatic nxt(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input int dx, input int dy,
                                        input bit h, input bit t, input int d);
      return {t, h, CB'(dy), CB'(dx), DW'(d)};
   endfunction

   task automatic put(input int p, input int v, input logic [FW-1:0] f);
      in_flit[p*FW +: FW] = f;
      in_vc[p*VB +: VB]   = VB'(v);
      in_valid[p]         = 1'b1;
   endtask

   task automatic do_reset();
      in_valid  = '0;
      in_flit   = '0;
      in_vc     = '0;
      credit_in = '0;
      stat_sel  = '0;
      rst_n     = 1'b0;
      nxt(2);
      rst_n = 1'b1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_credit_out"}, credit_out, 0);
      check({tag, "_out_flit"}, {63'd0, |out_flit}, 0);
      check({tag, "_out_vc"}, out_vc, 0);
      check({tag, "_err_ovf"}, err_overflow, 0);
      check({tag, "_err_prot"}, err_protocol, 0);
      check({tag, "_stat"}, stat_count, 0);
   endtask

   initial begin
      do_reset();
      check_reset("rst");

      // single flit L -> E, latency 2, credit back at t+2
      put(PL, 0, mk(2, 1, 1, 1, 'hA1));
      nxt();
      in_valid = '0;
      check("t1_lat1", out_valid, 0);
      nxt();
      check("t1_valid", out_valid, 5'b00100);
      check("t1_vc", out_vc[PE], 0);
      check("t1_flit", out_flit[PE*FW +: FW], mk(2, 1, 1, 1, 'hA1));
      check("t1_credit", credit_out, 10'h100);
      nxt();
      check("t1_done", {out_valid, credit_out}, 0);

      // credit exhaustion on E VC1
      do_reset();
      for (int i = 0; i < 6; i++) begin
         put(PW, 1, mk(2, 1, 1, 1, 'h20 + i));
         nxt();
      end
      in_valid = '0;
      nxt(4);
      check("t2_sent4", dep[PE], 4);
      check("t2_cred4", crd[PW*NV+1], 4);
      check("t2_no_ovf", err_overflow, 0);
      credit_in[PE*NV+1] = 1'b1;
      nxt();
      credit_in = '0;
      nxt(3);
      check("t2_sent5", dep[PE], 5);
      check("t2_last5", e_data[$], 'h24);
      credit_in[PE*NV+1] = 1'b1;
      nxt();
      credit_in = '0;
      nxt(3);
      check("t2_sent6", dep[PE], 6);
      check("t2_last6", e_data[$], 'h25);
      credit_in[PE*NV+1] = 1'b1;
      nxt();
      credit_in = '0;
      nxt(3);
      check("t2_drained", dep[PE], 6);

      // wormhole lock on E VC0, VC1 interleaves
      do_reset();
      credit_in = '1;
      put(PW, 0, mk(2, 1, 1, 0, 'h30));
      nxt();
      put(PN, 0, mk(2, 1, 1, 0, 'h40));
      put(PW, 0, mk(2, 1, 0, 0, 'h31));
      nxt();
      in_valid = '0;
      put(PN, 0, mk(2, 1, 0, 1, 'h41));
      nxt();
      in_valid = '0;
      put(PN, 1, mk(2, 1, 1, 1, 'h50));
      nxt();
      in_valid = '0;
      nxt();
      put(PW, 0, mk(2, 1, 0, 1, 'h32));
      nxt();
      in_valid = '0;
      nxt(10);
      exp3 = '{16'h30, 16'h31, 16'h50, 16'h32, 16'h40, 16'h41};
      exv3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      check("t3_count", e_data.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3_data%0d", i), e_data[i], exp3[i]);
         check($sformatf("t3_vc%0d", i), e_vc[i], exv3[i]);
      end

      // W and S share E on different VCs
      do_reset();
      credit_in = '1;
      for (int i = 0; i < 6; i++) begin
         in_valid = '0;
         if (i < 5) put(PW, 0, mk(2, 1, 1, 1, 'h60 + i));
         if (i > 0) put(PS, 1, mk(2, 1, 1, 1, 'h70 + i - 1));
         nxt();
      end
      in_valid = '0;
      nxt(12);
      check("t4_count", e_data.size(), 10);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t4_data%0d", i), e_data[i],
               (i % 2 == 0) ? 'h60 + i/2 : 'h70 + i/2);
         check($sformatf("t4_cyc%0d", i), e_cyc[i] - e_cyc[0], i);
      end
      check("t4_no_ovf", err_overflow, 0);

      // overflow and protocol error flags
      do_reset();
      for (int i = 0; i < 4; i++) begin
         put(PN, 0, mk(1, 1, 1, 1, 'h80 + i));
         nxt();
      end
      in_valid = '0;
      nxt(4);
      check("t5_local4", dep[PL], 4);
      for (int i = 0; i < 4; i++) begin
         put(PN, 0, mk(1, 1, 1, 1, 'h90 + i));
         nxt();
      end
      in_valid = '0;
      check("t5_full_no_ovf", err_overflow, 0);
      put(PN, 0, mk(1, 1, 1, 1, 'h94));
      nxt();
      in_valid = '0;
      check("t5_ovf", err_overflow, 5'b00001);
      nxt(5);
      check("t5_ovf_held", err_overflow, 5'b00001);
      check("t5_stalled", dep[PL], 4);
      put(PS, 1, mk(2, 1, 0, 0, 'hBB));
      nxt();
      in_valid = '0;
      nxt(2);
      check("t5_prot", err_protocol, 5'b00010);
      check("t5_prot_credit", crd[PS*NV+1], 1);
      check("t5_prot_dropped", dep[PE], 0);
      do_reset();
      check("t5_rst_ovf", err_overflow, 0);
      check("t5_rst_prot", err_protocol, 0);

      // statistics, then reset in mid-packet
      credit_in[PN*NV+0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         put(PL, 0, mk(1, 2, 1, 1, 'hC0 + i));
         nxt();
      end
      in_valid = '0;
      nxt(5);
      check("t6_north7", dep[PN], 7);
      stat_sel = 3'd0;
      #1;
      check("t6_stat_n", stat_count, STAT_N);
      stat_sel = 3'd2;
      #1;
      check("t6_stat_e", stat_count, 0);
      stat_sel = 3'd5;
      #1;
      check("t6_stat_oob", stat_count, 0);
      credit_in = '0;
      put(PL, 0, mk(2, 1, 1, 0, 'hD0));
      nxt();
      put(PL, 0, mk(2, 1, 0, 0, 'hD1));
      nxt();
      in_valid = '0;
      do_reset();
      check_reset("t6_rst");
      put(PW, 0, mk(2, 1, 1, 1, 'hE0));
      put(PL, 0, mk(1, 2, 1, 1, 'hE1));
      nxt();
      in_valid = '0;
      nxt();
      check("t6_after_valid", out_valid, 5'b00101);
      check("t6_after_e", out_flit[PE*FW +: FW], mk(2, 1, 1, 1, 'hE0));
      check("t6_after_n", out_flit[PN*FW +: FW], mk(1, 2, 1, 1, 'hE1));
      check("t6_after_credit", credit_out, 10'h140);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/noc_router_vc.md
# noc_router_vc

Five-port 2D-mesh router with virtual channels, wormhole switching and credit-based flow control. It succeeds the single-channel ready/valid mesh router and adds several features:
- parametrised VC count and buffer depth;
- multi-flit packets whose output-VC path is held from head to tail;
- explicit credit counters per output VC;
- sticky error flags.

It is instantiated once per mesh node. The local port connects to the TPC network interface.

## Interface
Parameters:
- DATA_WIDTH, 256, payload bits per flit
- COORD_BITS, 4, bits per X/Y coordinate
- NUM_VC, 2, virtual channels per port (≥1); VC_BITS = max(1, clog2(NUM_VC))
- BUF_DEPTH, 4, flits per input VC buffer (power of 2, ≥2)
- ROUTER_X, 0 and ROUTER_Y, 0, this node's coordinates

Flit layout:
- FLIT_W = DATA_WIDTH+2*COORD_BITS+2.
- Fields, LSB first: data, dest_x, dest_y, head, tail.

Port packing:
- Port index p: 0=N, 1=S, 2=E, 3=W, 4=L.
- Per-port buses are packed at p*width.
- VC vectors are indexed p*NUM_VC+vc.

Ports (clock and reset first; reset is synchronous, active-low, a single clock domain):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_flit  in  5*FLIT_W  arriving flits
- in_vc  in  5*VC_BITS  VC of arriving flit
- in_valid  in  5  flit present this cycle; no ready, since the upstream holds credits
- credit_out  out  5*NUM_VC  one-cycle pulse returning one buffer slot upstream
- out_flit  out  5*FLIT_W  departing flits (registered)
- out_vc  out  5*VC_BITS  VC of departing flit (same as arrival VC; no VC reallocation)
- out_valid  out  5  departing flit valid
- credit_in  in  5*NUM_VC  credit pulses from downstream
- err_overflow  out  5  sticky: flit arrived at a full VC buffer
- err_protocol  out  5  sticky: body/tail flit reached an IDLE input VC
- stat_sel  in  3  output port selected for statistics
- stat_count  out  32  flits sent on selected output

## Operation
Input side:
- Each (port, VC) has a BUF_DEPTH FIFO.
- A write into a full FIFO drops the flit and sets err_overflow[p].

Per input VC state machine:
- IDLE: the FIFO head must be a head flit.
  - Compute the XY route: dest_x<ROUTER_X→W; dest_x>ROUTER_X→E; else dest_y<ROUTER_Y→S; dest_y>ROUTER_Y→N; else L.
  - On grant of a head flit with tail=0, store the route and go to ACTIVE.
  - A head+tail flit stays IDLE.
  - A non-head flit at the head is popped and dropped, sets err_protocol[p], and returns a credit.
- ACTIVE: body flits use the stored route. Grant of a tail flit returns the VC to IDLE.

Output VC lock:
- Locked on grant of a head flit with tail=0; released on grant of its tail.
- A head flit requests only an unlocked output VC.
- Body flits of the owner always pass the lock check.

Credits:
- Counter per (output, VC), width clog2(BUF_DEPTH+1), reset to BUF_DEPTH.
- A request requires credit>0.
- Counter is decremented on send and incremented on credit_in.
- Simultaneous send and credit_in leaves it unchanged.
- Saturates at BUF_DEPTH.

Separable allocation each cycle:
1. Per input, pick one eligible VC round-robin.
2. Per output, pick one input round-robin.

Allocation rules:
- Round-robin pointers advance to one past the winner, and only on a grant.
- Inputs that lose stage 2 idle that cycle.
- At most one flit leaves each input and each output per cycle.

## Timing
- Flit with in_valid in cycle t: buffered at the end of t, allocated in t+1, visible on out_* in t+2 (minimum latency 2).
- credit_out for a popped flit pulses in the cycle after the pop (t+2 at minimum latency). Dropped protocol-error flits also return a credit.
- A credit_in in cycle t is usable for allocation in t+1.
- Write and pop on the same full FIFO in the same cycle: the pop frees a slot, so the write succeeds.

Reset values, all cleared by rst_n=0 regardless of in-flight packets:
- out_valid=0, out_flit=0, out_vc=0, credit_out=0
- err_*=0, stat_count=0
- all FIFOs empty, VC states IDLE, locks clear, credits=BUF_DEPTH, RR pointers 0

## Configuration
- NOC_ROUTER_VC_STATS_EN defined: five 32-bit wrapping counters, one per output, increment on each out_valid. stat_count shows the counter for stat_sel; stat_sel≥5 reads 0.
- Undefined: no counters are built, and stat_count is tied to 0.

## Test plan
1. ROUTER_X=1, ROUTER_Y=1: single head+tail flit on L, VC0, dest (2,1), cycle t → E out_valid at t+2 with out_vc=0; credit_out[L*NUM_VC+0] pulses at t+2.
2. E credit_in held 0: send 6 single-flit packets W→E on VC1 → exactly 4 depart and 2 stay buffered (W VC1 FIFO holds 2); one credit_in pulse → exactly one more departs.
3. 3-flit packet W→E on VC0 started, then head N→E on VC0 → N waits until W's tail departs; N's VC1 packet to E interleaves with the W flits meanwhile.
4. W and S both stream to E on different VCs with ample credits → E grants alternate W,S,W,S… every cycle.
5. L output credits 0, 5 flits written into one VC at a dest_x=ROUTER_X, dest_y=ROUTER_Y buffer → 5th dropped, err_overflow[p]=1 and held until reset; a body flit into an IDLE VC sets err_protocol[p].
6. With NOC_ROUTER_VC_STATS_EN: 7 flits out of N, stat_sel=0 → stat_count=7; reset mid-packet → everything returns to its reset values, and a new head flit then routes normally.
